// File: rtl/execute_top_if.sv
// rtl/execute_top_if.sv - execute stage bus: E-stage inputs, forwarding sources, redirect and M-stage outputs
// Ports (modports):
//   master  drives stall, E-stage controls/operands and forwarding sources; observes outputs
//   slave   the execute stage: consumes the above, drives PCSrcE/PCTargetE/BusyE and *M fields
interface execute_top_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  RegWriteE;
  logic [1:0]            ResultSrcE;
  logic                  MemWriteE;
  logic [2:0]            MemoryOpE;
  logic                  JumpE;
  logic                  JalrE;
  logic                  BranchE;
  logic [2:0]            BranchTypeE;
  logic [3:0]            ALUControlE;
  logic                  ALUSrcE;
  logic [DATA_WIDTH-1:0] RD1E;
  logic [DATA_WIDTH-1:0] RD2E;
  logic [DATA_WIDTH-1:0] PCE;
  logic [DATA_WIDTH-1:0] PCPlus4E;
  logic [DATA_WIDTH-1:0] ImmExtE;
  logic [4:0]            RdE;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [DATA_WIDTH-1:0] ResultW;
  logic [DATA_WIDTH-1:0] ReadDataM;

  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  BusyE;
  logic                  RegWriteM;
  logic [1:0]            ResultSrcM;
  logic                  MemWriteM;
  logic [2:0]            MemoryOpM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [4:0]            RdM;
  logic [DATA_WIDTH-1:0] PCPlus4M;

  modport master (
    output stall, RegWriteE, ResultSrcE, MemWriteE, MemoryOpE, JumpE, JalrE, BranchE,
           BranchTypeE, ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE,
           ForwardAE, ForwardBE, ResultW, ReadDataM,
    input  PCSrcE, PCTargetE, BusyE, RegWriteM, ResultSrcM, MemWriteM, MemoryOpM,
           ALUResultM, WriteDataM, RdM, PCPlus4M
  );

  modport slave (
    input  stall, RegWriteE, ResultSrcE, MemWriteE, MemoryOpE, JumpE, JalrE, BranchE,
           BranchTypeE, ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE,
           ForwardAE, ForwardBE, ResultW, ReadDataM,
    output PCSrcE, PCTargetE, BusyE, RegWriteM, ResultSrcM, MemWriteM, MemoryOpM,
           ALUResultM, WriteDataM, RdM, PCPlus4M
  );
endinterface

// File: rtl/execute_top.sv
// rtl/execute_top.sv - RV32IM execute stage: forwarding, ALU/MUL, iterative divider, branch resolve, E->M register
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   io_bus       execute_top_if.slave: E-stage controls/operands, forwarding sources and stall in;
//                PCSrcE/PCTargetE redirect, BusyE divider freeze request and registered M-stage fields out
module execute_top #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  execute_top_if.slave io_bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  localparam logic [5:0] CNT_INIT = 6'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t            r_state;
  logic [5:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_want_rem;

  logic                  r_reg_write_m;
  logic [1:0]            r_result_src_m;
  logic                  r_mem_write_m;
  logic [2:0]            r_memory_op_m;
  logic [DATA_WIDTH-1:0] r_alu_result_m;
  logic [DATA_WIDTH-1:0] r_write_data_m;
  logic [4:0]            r_rd_m;
  logic [DATA_WIDTH-1:0] r_pc_plus4_m;

  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [4:0]            w_shamt;
  logic [DATA_WIDTH-1:0] w_alu_raw;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_cond;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic                  w_is_div;
  logic                  w_div_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_div_q;
  logic [DATA_WIDTH-1:0] w_div_r;
  logic [DATA_WIDTH-1:0] w_div_result;
  logic                  w_busy;

  // Forwarding; source 10 is our own registered ALU result
  always_comb begin
    case (io_bus.ForwardAE)
      2'b00:   w_src_a = io_bus.RD1E;
      2'b01:   w_src_a = io_bus.ResultW;
      2'b10:   w_src_a = r_alu_result_m;
      default: w_src_a = io_bus.ReadDataM;
    endcase
    case (io_bus.ForwardBE)
      2'b00:   w_fwd_b = io_bus.RD2E;
      2'b01:   w_fwd_b = io_bus.ResultW;
      2'b10:   w_fwd_b = r_alu_result_m;
      default: w_fwd_b = io_bus.ReadDataM;
    endcase
  end

  assign w_src_b = io_bus.ALUSrcE ? io_bus.ImmExtE : w_fwd_b;
  assign w_shamt = w_src_b[4:0];

  // Single-cycle ALU; divide codes produce 0 here, the divider result is muxed in during DONE
  always_comb begin
    w_alu_raw = '0;
    case (io_bus.ALUControlE)
      ALU_ADD:  w_alu_raw = w_src_a + w_src_b;
      ALU_SUB:  w_alu_raw = w_src_a - w_src_b;
      ALU_AND:  w_alu_raw = w_src_a & w_src_b;
      ALU_OR:   w_alu_raw = w_src_a | w_src_b;
      ALU_XOR:  w_alu_raw = w_src_a ^ w_src_b;
      ALU_SLL:  w_alu_raw = w_src_a << w_shamt;
      ALU_SRL:  w_alu_raw = w_src_a >> w_shamt;
      ALU_SRA:  w_alu_raw = $signed(w_src_a) >>> w_shamt;
      ALU_SLT:  w_alu_raw = {{(DATA_WIDTH-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU: w_alu_raw = {{(DATA_WIDTH-1){1'b0}}, w_src_a < w_src_b};
      ALU_LUI:  w_alu_raw = w_src_b;
      ALU_MUL:  w_alu_raw = w_src_a * w_src_b;
      default:  w_alu_raw = '0;
    endcase
  end

  // Branch conditions compare against the forwarded rs2, never the immediate
  always_comb begin
    w_cond = 1'b0;
    case (io_bus.BranchTypeE)
      3'b000:  w_cond = (w_src_a == w_fwd_b);
      3'b001:  w_cond = (w_src_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_src_a < w_fwd_b);
      3'b111:  w_cond = (w_src_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum       = w_src_a + io_bus.ImmExtE;
  assign io_bus.PCSrcE    = io_bus.JumpE | (io_bus.BranchE & w_cond);
  assign io_bus.PCTargetE = io_bus.JalrE ? {w_jalr_sum[DATA_WIDTH-1:1], 1'b0}
                                         : (io_bus.PCE + io_bus.ImmExtE);

  // Divider operand preparation: codes 11xx, bit0 = unsigned, bit1 = remainder
  assign w_is_div     = (io_bus.ALUControlE[3:2] == 2'b11);
  assign w_div_signed = ~io_bus.ALUControlE[0];
  assign w_a_neg      = w_div_signed & w_src_a[DATA_WIDTH-1];
  assign w_b_neg      = w_div_signed & w_src_b[DATA_WIDTH-1];
  assign w_abs_a      = w_a_neg ? (-w_src_a) : w_src_a;
  assign w_abs_b      = w_b_neg ? (-w_src_b) : w_src_b;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract when it fits. The remainder stays below the divisor, so W bits suffice
  // after the subtract even though the shifted value needs W+1 for the compare.
  assign w_rem_shift = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_dvs});
  assign w_diff      = w_rem_shift[DATA_WIDTH-1:0] - r_dvs;

  // Divide by zero leaves quotient all ones and remainder = |dividend|; r_neg_q is
  // cleared for a zero divisor so the all-ones quotient is not negated.
  assign w_div_q      = r_neg_q ? (-r_quo) : r_quo;
  assign w_div_r      = r_neg_r ? (-r_rem) : r_rem;
  assign w_div_result = r_want_rem ? w_div_r : w_div_q;

  // Busy is combinational in IDLE so the very first divide cycle already freezes the front end
  assign w_busy       = (r_state == S_RUN) | ((r_state == S_IDLE) & w_is_div);
  assign io_bus.BusyE = w_busy;

  assign w_alu_result = (r_state == S_DONE) ? w_div_result : w_alu_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_want_rem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            r_quo      <= w_abs_a;
            r_rem      <= '0;
            r_dvs      <= w_abs_b;
            r_neg_q    <= (w_a_neg ^ w_b_neg) & (w_src_b != '0);
            r_neg_r    <= w_a_neg;
            r_want_rem <= io_bus.ALUControlE[1];
            r_cnt      <= CNT_INIT;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_rem_shift[DATA_WIDTH-1:0];
          r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold the result until the pipeline is free to take it
          if (!io_bus.stall) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // E->M register; a busy cycle inserts a bubble so nothing downstream commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_mem_write_m  <= 1'b0;
      r_memory_op_m  <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_rd_m         <= '0;
      r_pc_plus4_m   <= '0;
    end else if (!io_bus.stall) begin
      if (w_busy) begin
        r_reg_write_m  <= 1'b0;
        r_result_src_m <= 2'b00;
        r_mem_write_m  <= 1'b0;
        r_memory_op_m  <= '0;
        r_alu_result_m <= '0;
        r_write_data_m <= '0;
        r_rd_m         <= '0;
        r_pc_plus4_m   <= '0;
      end else begin
        r_reg_write_m  <= io_bus.RegWriteE;
        r_result_src_m <= io_bus.ResultSrcE;
        r_mem_write_m  <= io_bus.MemWriteE;
        r_memory_op_m  <= io_bus.MemoryOpE;
        r_alu_result_m <= w_alu_result;
        r_write_data_m <= w_fwd_b;
        r_rd_m         <= io_bus.RdE;
        r_pc_plus4_m   <= io_bus.PCPlus4E;
      end
    end
  end

  assign io_bus.RegWriteM  = r_reg_write_m;
  assign io_bus.ResultSrcM = r_result_src_m;
  assign io_bus.MemWriteM  = r_mem_write_m;
  assign io_bus.MemoryOpM  = r_memory_op_m;
  assign io_bus.ALUResultM = r_alu_result_m;
  assign io_bus.WriteDataM = r_write_data_m;
  assign io_bus.RdM        = r_rd_m;
  assign io_bus.PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_top.sv
// tb/tb_execute_top.sv - self-checking bench for execute_top: vector table, random model check, divider sequences
module tb_execute_top;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_top_if #(.DATA_WIDTH(W)) bus ();
  execute_top #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .io_bus(bus));

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        alusrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] resw;
    logic [31:0] rdm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  rsrc;
    logic [2:0]  memop;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic [2:0]  btype;
  } vin_t;

  typedef struct packed {
    vin_t        in;
    logic [31:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_alum;
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vin_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic alusrc);
    vin_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.alusrc = alusrc;
    v.fa = 2'b00; v.fb = 2'b00; v.resw = 32'hA5A5_0001; v.rdm = 32'h5A5A_0002;
    v.pc = 32'h0000_1000; v.pc4 = 32'h0000_1004; v.rd = 5'd3; v.regwrite = 1'b1;
    v.memwrite = 1'b0; v.rsrc = 2'b00; v.memop = 3'b010;
    v.jump = 1'b0; v.jalr = 1'b0; v.branch = 1'b0; v.btype = 3'b000;
    return v;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic alusrc, input logic [31:0] exp);
    vec_t t;
    t.in  = mk(op, rd1, rd2, imm, alusrc);
    t.exp = exp;
    return t;
  endfunction

  function automatic vin_t nop_vec();
    vin_t v;
    v = mk(4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    v.regwrite = 1'b0; v.memop = 3'b000; v.pc = 32'h0; v.pc4 = 32'h0;
    v.resw = 32'h0; v.rdm = 32'h0;
    return v;
  endfunction

  // Reference model, written directly from the instruction-set rules
  function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] resw, input logic [31:0] alum,
                                          input logic [31:0] rdm);
    if (sel == 2'b00) return rf;
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return alum;
    return rdm;
  endfunction

  function automatic logic [31:0] div_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic want_rem;
    sgn      = (op == 4'hC) || (op == 4'hE);
    want_rem = (op == 4'hE) || (op == 4'hF);
    if (b == 32'h0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return want_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return want_rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      prod;
    sh = int'(b % 32);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return 32'($signed(a) >>> sh);
      4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return b;
      4'hB: begin
        prod = longint'($signed(a)) * longint'($signed(b));
        return prod[31:0];
      end
      default: return div_ref(op, a, b);
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input vin_t v);
    bus.RegWriteE = v.regwrite; bus.ResultSrcE = v.rsrc; bus.MemWriteE = v.memwrite;
    bus.MemoryOpE = v.memop; bus.JumpE = v.jump; bus.JalrE = v.jalr; bus.BranchE = v.branch;
    bus.BranchTypeE = v.btype; bus.ALUControlE = v.op; bus.ALUSrcE = v.alusrc;
    bus.RD1E = v.rd1; bus.RD2E = v.rd2; bus.PCE = v.pc; bus.PCPlus4E = v.pc4;
    bus.ImmExtE = v.imm; bus.RdE = v.rd; bus.ForwardAE = v.fa; bus.ForwardBE = v.fb;
    bus.ResultW = v.resw; bus.ReadDataM = v.rdm;
  endtask

  // One single-cycle instruction: combinational redirect checks, then the M register after the edge
  task automatic step(input vin_t v, input logic [31:0] exp_alu, input string tag);
    logic [31:0] a;
    logic [31:0] fb;
    logic [31:0] tgt;
    drive(v);
    a   = fwd_ref(v.fa, v.rd1, v.resw, exp_alum, v.rdm);
    fb  = fwd_ref(v.fb, v.rd2, v.resw, exp_alum, v.rdm);
    tgt = v.jalr ? ((a + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    #2;
    check({tag, " PCSrcE"}, 32'(bus.PCSrcE), 32'(v.jump | (v.branch & br_ref(v.btype, a, fb))));
    check({tag, " PCTargetE"}, bus.PCTargetE, tgt);
    check({tag, " BusyE"}, 32'(bus.BusyE), 32'd0);
    @(posedge clk); #1;
    check({tag, " ALUResultM"}, bus.ALUResultM, exp_alu);
    check({tag, " WriteDataM"}, bus.WriteDataM, fb);
    check({tag, " ctrlM"}, {19'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.MemoryOpM, bus.RdM},
          {19'd0, v.regwrite, v.memwrite, v.rsrc, v.memop, v.rd});
    check({tag, " PCPlus4M"}, bus.PCPlus4M, v.pc4);
    exp_alum = exp_alu;
  endtask

  // A divide from IDLE through DONE, optionally stalled in DONE, ending with the result in M
  task automatic run_div(input vin_t v, input logic [31:0] exp, input string tag, input int stall_cycles);
    int cnt;
    drive(v);
    #1;
    check({tag, " BusyE idle"}, 32'(bus.BusyE), 32'd1);
    cnt = 0;
    while (bus.BusyE === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      check({tag, " bubble"}, {23'd0, bus.RegWriteM, bus.MemWriteM, bus.RdM, bus.ResultSrcM}, 32'd0);
    end
    check({tag, " busy cycles"}, 32'(cnt), 32'd33);
    if (stall_cycles > 0) begin
      bus.stall = 1'b1;
      for (int i = 0; i < stall_cycles; i++) begin
        @(posedge clk); #1;
        check({tag, " stall BusyE"}, 32'(bus.BusyE), 32'd0);
        check({tag, " stall held"}, {bus.ALUResultM[30:0], bus.RegWriteM}, 32'd0);
      end
      bus.stall = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, " result"}, bus.ALUResultM, exp);
    check({tag, " RegWriteM"}, 32'(bus.RegWriteM), 32'(v.regwrite));
    check({tag, " RdM"}, 32'(bus.RdM), 32'(v.rd));
    check({tag, " WriteDataM"}, bus.WriteDataM, v.rd2);
    exp_alum = exp;
    drive(nop_vec());
  endtask

  initial begin
    vin_t v;
    logic [31:0] a;
    logic [31:0] fb;

    tbl.push_back(mkv(4'h0, 32'd5,          32'd0,          32'd7,          1'b1, 32'd12));
    tbl.push_back(mkv(4'h1, 32'd3,          32'd5,          32'd0,          1'b0, 32'hFFFF_FFFE));
    tbl.push_back(mkv(4'h2, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'd0,          1'b0, 32'h00F0_000F));
    tbl.push_back(mkv(4'h3, 32'hF000_0000,  32'h0000_000F,  32'd0,          1'b0, 32'hF000_000F));
    tbl.push_back(mkv(4'h4, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'd0,          1'b0, 32'hF0F0_0F0F));
    tbl.push_back(mkv(4'h5, 32'd1,          32'h0000_0024,  32'd0,          1'b0, 32'h0000_0010));
    tbl.push_back(mkv(4'h6, 32'h8000_0000,  32'd31,         32'd0,          1'b0, 32'h0000_0001));
    tbl.push_back(mkv(4'h7, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 32'hF800_0000));
    tbl.push_back(mkv(4'h7, 32'h8000_0000,  32'h0000_0020,  32'd0,          1'b0, 32'h8000_0000));
    tbl.push_back(mkv(4'h8, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32'd1));
    tbl.push_back(mkv(4'h9, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32'd0));
    tbl.push_back(mkv(4'hA, 32'd0,          32'd0,          32'h1234_5000,  1'b1, 32'h1234_5000));
    tbl.push_back(mkv(4'hB, 32'h0001_0000,  32'h0001_0001,  32'd0,          1'b0, 32'h0001_0000));
    tbl.push_back(mkv(4'hB, 32'hFFFF_FFFD,  32'd5,          32'd0,          1'b0, 32'hFFFF_FFF1));

    // Reset state
    reset = 1'b1;
    bus.stall = 1'b0;
    drive(nop_vec());
    repeat (2) @(posedge clk);
    #1;
    check("reset ALUResultM", bus.ALUResultM, 32'd0);
    check("reset WriteDataM", bus.WriteDataM, 32'd0);
    check("reset PCPlus4M", bus.PCPlus4M, 32'd0);
    check("reset ctrlM", {19'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.MemoryOpM, bus.RdM}, 32'd0);
    check("reset BusyE", 32'(bus.BusyE), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    exp_alum = 32'd0;

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Forwarding from ALUResultM and ReadDataM
    step(mk(4'h0, 32'h10, 32'h0, 32'h0, 1'b1), 32'h10, "fwd setup");
    v = mk(4'h1, 32'h999, 32'h777, 32'h0, 1'b0);
    v.fa = 2'b10; v.fb = 2'b11; v.rdm = 32'h3;
    step(v, 32'h0000_000D, "fwd sub");

    // Branch taken / not taken on the same operands
    v = mk(4'h0, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
    v.branch = 1'b1; v.btype = 3'b100; v.pc = 32'h100;
    drive(v);
    #2;
    check("blt PCSrcE", 32'(bus.PCSrcE), 32'd1);
    check("blt PCTargetE", bus.PCTargetE, 32'h0000_0120);
    v.btype = 3'b110;
    drive(v);
    #1;
    check("bltu PCSrcE", 32'(bus.PCSrcE), 32'd0);
    @(posedge clk); #1;
    exp_alum = 32'h0000_0000;
    check("branch ALUResultM", bus.ALUResultM, exp_alum);

    // Random single-cycle instructions against the model
    for (int i = 0; i < 150; i++) begin
      v = mk(4'($urandom_range(0, 11)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) v.rd2 = 32'($urandom_range(0, 40));
      v.fa = 2'($urandom_range(0, 3)); v.fb = 2'($urandom_range(0, 3));
      v.resw = $urandom; v.rdm = $urandom; v.pc = $urandom; v.pc4 = v.pc + 32'd4;
      v.rd = 5'($urandom_range(0, 31)); v.regwrite = 1'($urandom_range(0, 1));
      v.memwrite = 1'($urandom_range(0, 1)); v.rsrc = 2'($urandom_range(0, 2));
      v.memop = 3'($urandom_range(0, 7)); v.jump = ($urandom_range(0, 7) == 0);
      v.jalr = 1'($urandom_range(0, 1)); v.branch = 1'($urandom_range(0, 1));
      v.btype = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) v.rd2 = v.rd1;
      a  = fwd_ref(v.fa, v.rd1, v.resw, exp_alum, v.rdm);
      fb = fwd_ref(v.fb, v.rd2, v.resw, exp_alum, v.rdm);
      step(v, alu_ref(v.op, a, v.alusrc ? v.imm : fb), $sformatf("rnd%0d", i));
    end

    // Divider sequences and corners
    run_div(mk(4'hC, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0), 32'hFFFF_FFFD, "div -7/2", 0);
    run_div(mk(4'hE, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0), 32'hFFFF_FFFF, "rem -7/2", 3);
    run_div(mk(4'hD, 32'h0000_1234, 32'd0, 32'd0, 1'b0), 32'hFFFF_FFFF, "divu x/0", 0);
    run_div(mk(4'hC, 32'hFFFF_FF00, 32'd0, 32'd0, 1'b0), 32'hFFFF_FFFF, "div -x/0", 0);
    run_div(mk(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0), 32'h8000_0000, "div ovf", 0);
    run_div(mk(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0), 32'h0000_0000, "rem ovf", 0);
    run_div(mk(4'hE, 32'hFFFF_FF00, 32'd0, 32'd0, 1'b0), 32'hFFFF_FF00, "rem x/0", 0);
    run_div(mk(4'hF, 32'h0000_DEAD, 32'd0, 32'd0, 1'b0), 32'h0000_DEAD, "remu x/0", 0);
    for (int i = 0; i < 4; i++) begin
      v = mk(4'($urandom_range(12, 15)), $urandom,
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 100)) : $urandom, 32'd0, 1'b0);
      if ($urandom_range(0, 1) == 1) v.rd2 = -v.rd2;
      v.rd = 5'($urandom_range(1, 31));
      run_div(v, div_ref(v.op, v.rd1, v.rd2), $sformatf("rdiv%0d", i), 0);
    end

    // Reset in the middle of RUN, then re-issue
    v = mk(4'hD, 32'd100, 32'd7, 32'd0, 1'b0);
    drive(v);
    repeat (11) @(posedge clk);
    #1;
    check("mid-run BusyE before reset", 32'(bus.BusyE), 32'd1);
    drive(nop_vec());
    reset = 1'b1;
    #1;
    check("reset mid-run BusyE", 32'(bus.BusyE), 32'd0);
    check("reset mid-run ALUResultM", bus.ALUResultM, 32'd0);
    check("reset mid-run ctrlM", {22'd0, bus.RegWriteM, bus.MemWriteM, bus.RdM, bus.ResultSrcM}, 32'd0);
    #2 reset = 1'b0;
    exp_alum = 32'd0;
    @(posedge clk); #1;
    run_div(v, 32'd14, "divu after reset", 0);
    step(mk(4'h1, 32'h0, 32'd1, 32'd0, 1'b0), 32'hFFFF_FFFF, "post-div sub");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
